sdr_tune_ctrl: RTL and testbench

//  Byte-serial command parser that configures the SDR receive chain at run time.

---
 rtl/sdr_tune_ctrl_if.sv | 24 ++
 rtl/sdr_tune_ctrl.sv | 174 +++++++++++++++++
 tb/tb_sdr_tune_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sdr_tune_ctrl_if.sv
// Bundle of the UART-side byte streams and the run-time configuration outputs.
// master = host/driver side, slave = sdr_tune_ctrl.
interface sdr_tune_ctrl_if;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic        tx_active;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic [63:0] phase_inc_carr;
  logic [63:0] phase_inc_gen;
  logic [15:0] decim_ratio;
  logic        cfg_update;
  logic [7:0]  err_cnt;

  modport master (
    output rx_dv, rx_byte, tx_active,
    input  tx_dv, tx_byte, phase_inc_carr, phase_inc_gen, decim_ratio, cfg_update, err_cnt
  );

  modport slave (
    input  rx_dv, rx_byte, tx_active,
    output tx_dv, tx_byte, phase_inc_carr, phase_inc_gen, decim_ratio, cfg_update, err_cnt
  );
endinterface

// File: rtl/sdr_tune_ctrl.sv
// Byte-serial framed command parser that atomically updates NCO increments / CIC ratio.
// Latency: cfg output changes 2 edges after the CSUM byte; ACK/NAK strobe follows at least 1 cycle later.
// Backpressure: reply held in RESP while tx_active; bytes arriving in APPLY/RESP are dropped and counted.
module sdr_tune_ctrl #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter logic [63:0] DEF_INC_CARR = 64'h01ED3E9CFE280000,
  parameter logic [63:0] DEF_INC_GEN  = 64'h01ECC07802400000,
  parameter logic [15:0] DEF_DECIM    = 16'd1024,
  parameter logic [23:0] TIMEOUT_CYC  = 24'd1330000
) (
  input  logic           clk,
  input  logic           rst,
  sdr_tune_ctrl_if.slave bus
);

  localparam logic [7:0] CMD_CARR  = 8'h01;
  localparam logic [7:0] CMD_GEN   = 8'h02;
  localparam logic [7:0] CMD_DECIM = 8'h03;
  localparam logic [7:0] ACK       = 8'h06;
  localparam logic [7:0] NAK       = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_PAYLOAD, ST_CSUM, ST_APPLY, ST_RESP
  } state_t;

  state_t      state, nxt;
  logic [7:0]  cmd_q, csum_q, resp_q;
  logic [63:0] shadow_q;
  logic [3:0]  byte_cnt;
  logic [23:0] tmo_cnt;
  logic [63:0] carr_q, gen_q;
  logic [15:0] decim_q;
  logic [7:0]  err_q, tx_byte_q;
  logic        tx_dv_q, upd_q;

  logic        in_frame, timeout, cmd_ok, decim_bad;
  logic        load_cmd, shift_en, set_resp, nak, drop, fire, apply;
  logic [7:0]  resp_val;
  logic [8:0]  err_sum;

  assign in_frame  = (state == ST_CMD) || (state == ST_PAYLOAD) || (state == ST_CSUM);
  assign timeout   = in_frame && !bus.rx_dv && (tmo_cnt >= TIMEOUT_CYC);
  assign cmd_ok    = (bus.rx_byte == CMD_CARR) || (bus.rx_byte == CMD_GEN) ||
                     (bus.rx_byte == CMD_DECIM);
  assign decim_bad = (cmd_q == CMD_DECIM) && (shadow_q[15:0] < 16'd2);

  always_comb begin
    nxt      = state;
    load_cmd = 1'b0;
    shift_en = 1'b0;
    set_resp = 1'b0;
    resp_val = ACK;
    nak      = 1'b0;
    drop     = 1'b0;
    fire     = 1'b0;
    apply    = 1'b0;
    case (state)
      ST_IDLE: if (bus.rx_dv && bus.rx_byte == SYNC_BYTE) nxt = ST_CMD;
      ST_CMD: begin
        if (bus.rx_dv) begin
          if (cmd_ok) begin
            load_cmd = 1'b1;
            nxt      = ST_PAYLOAD;
          end else begin
            set_resp = 1'b1;
            resp_val = NAK;
            nak      = 1'b1;
            nxt      = ST_RESP;
          end
        end else if (timeout) begin
          nxt = ST_IDLE;
        end
      end
      ST_PAYLOAD: begin
        if (bus.rx_dv) begin
          shift_en = 1'b1;
          if (byte_cnt == 4'd1) nxt = ST_CSUM;
        end else if (timeout) begin
          nxt = ST_IDLE;
        end
      end
      ST_CSUM: begin
        if (bus.rx_dv) begin
          if (bus.rx_byte == csum_q) begin
            nxt = ST_APPLY;
          end else begin
            set_resp = 1'b1;
            resp_val = NAK;
            nak      = 1'b1;
            nxt      = ST_RESP;
          end
        end else if (timeout) begin
          nxt = ST_IDLE;
        end
      end
      ST_APPLY: begin
        drop     = bus.rx_dv;
        set_resp = 1'b1;
        nxt      = ST_RESP;
        if (decim_bad) begin
          resp_val = NAK;
          nak      = 1'b1;
        end else begin
          apply = 1'b1;
        end
      end
      ST_RESP: begin
        drop = bus.rx_dv;
        if (!bus.tx_active) begin
          fire = 1'b1;
          nxt  = ST_IDLE;
        end
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // NAK and a dropped byte can land in the same APPLY cycle, so sum the events.
  assign err_sum = {1'b0, err_q} + {8'd0, nak} + {8'd0, drop} + {8'd0, timeout};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cmd_q     <= 8'd0;
      csum_q    <= 8'd0;
      resp_q    <= 8'd0;
      shadow_q  <= 64'd0;
      byte_cnt  <= 4'd0;
      tmo_cnt   <= 24'd0;
      carr_q    <= DEF_INC_CARR;
      gen_q     <= DEF_INC_GEN;
      decim_q   <= DEF_DECIM;
      err_q     <= 8'd0;
      tx_byte_q <= 8'd0;
      tx_dv_q   <= 1'b0;
      upd_q     <= 1'b0;
    end else begin
      state   <= nxt;
      tx_dv_q <= fire;
      upd_q   <= apply;
      err_q   <= err_sum[8] ? 8'hFF : err_sum[7:0];
      tmo_cnt <= (!in_frame || bus.rx_dv) ? 24'd0 : tmo_cnt + 24'd1;
      if (fire)     tx_byte_q <= resp_q;
      if (set_resp) resp_q    <= resp_val;
      if (load_cmd) begin
        cmd_q    <= bus.rx_byte;
        csum_q   <= bus.rx_byte;
        shadow_q <= 64'd0;
        byte_cnt <= (bus.rx_byte == CMD_DECIM) ? 4'd2 : 4'd8;
      end
      if (shift_en) begin
        shadow_q <= {shadow_q[55:0], bus.rx_byte};
        csum_q   <= csum_q ^ bus.rx_byte;
        byte_cnt <= byte_cnt - 4'd1;
      end
      if (apply) begin
        case (cmd_q)
          CMD_CARR: carr_q  <= shadow_q;
          CMD_GEN:  gen_q   <= shadow_q;
          default:  decim_q <= shadow_q[15:0];
        endcase
      end
    end
  end

  assign bus.tx_dv          = tx_dv_q;
  assign bus.tx_byte        = tx_byte_q;
  assign bus.phase_inc_carr = carr_q;
  assign bus.phase_inc_gen  = gen_q;
  assign bus.decim_ratio    = decim_q;
  assign bus.cfg_update     = upd_q;
  assign bus.err_cnt        = err_q;

endmodule

// File: tb/tb_sdr_tune_ctrl.sv
// Scoreboarded bench for sdr_tune_ctrl: expected replies queued per frame, checked on tx_dv.
module tb_sdr_tune_ctrl;
  localparam logic [23:0] TMO = 24'd200;
  localparam logic [63:0] DEF_CARR = 64'h01ED3E9CFE280000;
  localparam logic [63:0] DEF_GEN  = 64'h01ECC07802400000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdr_tune_ctrl_if bus ();

  sdr_tune_ctrl #(.TIMEOUT_CYC(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_err = 0;
  int tx_cnt = 0;
  int upd_cnt = 0;
  int exp_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] fr[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.cfg_update === 1'b1) upd_cnt++;
    if (bus.tx_dv === 1'b1) begin
      tx_cnt++;
      if (exp_q.size() == 0) chk("tx_unexpected", 64'(bus.tx_byte), 64'hFFFF);
      else chk("tx_byte", 64'(bus.tx_byte), 64'(exp_q.pop_front()));
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_dv   = 1'b1;
    bus.rx_byte = b;
    @(posedge clk); #1;
    bus.rx_dv   = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] f[$]);
    foreach (f[i]) send(f[i]);
  endtask

  function automatic logic [7:0] csum_of(input logic [7:0] f[$]);
    logic [7:0] x = 8'd0;
    for (int i = 1; i < f.size(); i++) x ^= f[i];
    return x;
  endfunction

  task automatic drain();
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      chk("tx_drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int u0, t0;
    bus.rx_dv     = 1'b0;
    bus.rx_byte   = 8'd0;
    bus.tx_active = 1'b0;

    // 1: reset
    do_reset();
    chk("rst_carr",  bus.phase_inc_carr, DEF_CARR);
    chk("rst_gen",   bus.phase_inc_gen,  DEF_GEN);
    chk("rst_decim", 64'(bus.decim_ratio), 64'd1024);
    chk("rst_err",   64'(bus.err_cnt), 64'd0);
    chk("rst_txdv",  64'(bus.tx_dv), 64'd0);

    // 2: decimation writes
    u0 = upd_cnt;
    exp_q.push_back(8'h06);
    fr = '{8'hA5, 8'h03, 8'h04, 8'h00, 8'h07};
    send_frame(fr);
    drain();
    chk("decim_400", 64'(bus.decim_ratio), 64'h0400);
    chk("decim_upd1", 64'(upd_cnt - u0), 64'd1);
    exp_q.push_back(8'h06);
    fr = '{8'hA5, 8'h03, 8'h01, 8'hF4, 8'hF6};
    send_frame(fr);
    drain();
    chk("decim_1f4", 64'(bus.decim_ratio), 64'h01F4);
    chk("decim_upd2", 64'(upd_cnt - u0), 64'd2);

    // 3: bad checksum, then good
    u0 = upd_cnt;
    exp_q.push_back(8'h15);
    exp_err++;
    fr = '{8'hA5, 8'h01, 8'h01, 8'hED, 8'h3E, 8'h9C, 8'hFE, 8'h28, 8'h00, 8'h00, 8'h98};
    send_frame(fr);
    drain();
    chk("badcs_carr", bus.phase_inc_carr, DEF_CARR);
    chk("badcs_err", 64'(bus.err_cnt), 64'(exp_err));
    chk("badcs_noupd", 64'(upd_cnt - u0), 64'd0);
    exp_q.push_back(8'h06);
    fr[10] = 8'h99;
    send_frame(fr);
    drain();
    chk("goodcs_carr", bus.phase_inc_carr, 64'h01ED3E9CFE280000);
    chk("goodcs_upd", 64'(upd_cnt - u0), 64'd1);

    // 4: inter-byte timeout, then a full generator frame
    t0 = tx_cnt;
    fr = '{8'hA5, 8'h02, 8'h12, 8'h34};
    send_frame(fr);
    repeat (int'(TMO) + 10) @(posedge clk);
    @(negedge clk);
    exp_err++;
    chk("tmo_err", 64'(bus.err_cnt), 64'(exp_err));
    chk("tmo_notx", 64'(tx_cnt - t0), 64'd0);
    chk("tmo_gen", bus.phase_inc_gen, DEF_GEN);
    fr = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'hA5, 8'h55, 8'h66, 8'h77, 8'h88};
    fr.push_back(csum_of(fr));
    exp_q.push_back(8'h06);
    send_frame(fr);
    drain();
    chk("gen_set", bus.phase_inc_gen, 64'h112233A555667788);

    // 5: tx back-pressure, with a byte dropped during the hold
    t0 = tx_cnt;
    bus.tx_active = 1'b1;
    exp_q.push_back(8'h06);
    fr = '{8'hA5, 8'h03, 8'h00, 8'h10, 8'h13};
    send_frame(fr);
    send(8'hA5);
    exp_err++;
    repeat (480) @(posedge clk);
    @(negedge clk);
    chk("bp_hold_notx", 64'(tx_cnt - t0), 64'd0);
    chk("bp_decim", 64'(bus.decim_ratio), 64'h0010);
    chk("bp_drop_err", 64'(bus.err_cnt), 64'(exp_err));
    @(posedge clk); #1;
    bus.tx_active = 1'b0;
    @(negedge clk);
    chk("bp_rel_0", 64'(bus.tx_dv), 64'd0);
    @(negedge clk);
    chk("bp_rel_1", 64'(bus.tx_dv), 64'd1);
    @(negedge clk);
    chk("bp_rel_2", 64'(bus.tx_dv), 64'd0);
    chk("bp_once", 64'(tx_cnt - t0), 64'd1);

    // 6: invalid command, decim below 2, reset mid-payload
    exp_q.push_back(8'h15);
    exp_err++;
    fr = '{8'hA5, 8'h07};
    send_frame(fr);
    drain();
    chk("badcmd_err", 64'(bus.err_cnt), 64'(exp_err));
    u0 = upd_cnt;
    exp_q.push_back(8'h15);
    exp_err++;
    fr = '{8'hA5, 8'h03, 8'h00, 8'h01, 8'h02};
    send_frame(fr);
    drain();
    chk("decim1_keep", 64'(bus.decim_ratio), 64'h0010);
    chk("decim1_err", 64'(bus.err_cnt), 64'(exp_err));
    chk("decim1_noupd", 64'(upd_cnt - u0), 64'd0);
    t0 = tx_cnt;
    fr = '{8'hA5, 8'h01, 8'h11, 8'h22};
    send_frame(fr);
    do_reset();
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("midrst_carr", bus.phase_inc_carr, DEF_CARR);
    chk("midrst_gen", bus.phase_inc_gen, DEF_GEN);
    chk("midrst_decim", 64'(bus.decim_ratio), 64'd1024);
    chk("midrst_err", 64'(bus.err_cnt), 64'd0);
    chk("midrst_notx", 64'(tx_cnt - t0), 64'd0);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
